control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high. Ports: clock (clock), clear (reset).
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 clear  input  1  asynchronous active-high reset.
REQ-004 IR  input  32  registered instruction from the datapath; opcode IR[31:27].
REQ-005 ConOut  input  1  branch-condition flag from the datapath CON flip-flop.
REQ-006 HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn  output  1 each  datapath register load enables.
REQ-007 HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut  output  1 each  bus-drive selects.
REQ-008 Gra, Grb, Grc, RIn, ROut, BAOut, Conin  output  1 each  register-file select and enable, plus CON load.
REQ-009 memread, memwrite  output  1 each  memory strobes.
REQ-010 ALUCode  output  5  ALU operation.
REQ-011 run  output  1  high while executing; low in RST and HALT.

Function
REQ-012 The block SHALL be a Moore FSM.
- States: RST, T0..T7, HALT.
- One state per clock; transitions occur on the rising edge of clock.
- Every output not listed for a state SHALL be 0; ALUCode default is 5'b00000.
REQ-013 Fetch:
- T0: PCOut, MARIn, ZIn, ALUCode=5'b11111 (increment).
- T1: ZLoOut, PCIn, memread, MDRIn.
- T2: MDROut, IRIn.
- Then T3.
REQ-014 Decode SHALL sample IR[31:27] in T3 and in every later execute state.
REQ-015 Opcode map:
- ld=00000, st=00010, add=00011, sub=00100, and=00101, or=00110.
- addi=01100, br=10011, jr=10100, jal=10101, nop=11010, halt=11011.
- Any other opcode SHALL execute as nop.
REQ-016 add/sub/and/or:
- T3: Grb, ROut, YIn.
- T4: Grc, ROut, ZIn, ALUCode=opcode.
- T5: ZLoOut, Gra, RIn.
- Then T0.
REQ-017 addi:
- T3: Grb, ROut, YIn.
- T4: COut, ZIn, ALUCode=5'b00011.
- T5: ZLoOut, Gra, RIn.
- Then T0.
REQ-018 ld:
- T3: Grb, BAOut, YIn.
- T4: COut, ZIn, ALUCode=5'b00011.
- T5: ZLoOut, MARIn.
- T6: memread, MDRIn.
- T7: MDROut, Gra, RIn.
- Then T0.
REQ-019 st:
- T3 to T5 as ld.
- T6: Gra, ROut, MDRIn.
- T7: memwrite.
- Then T0.
REQ-020 br:
- T3: Gra, ROut, Conin.
- T4: PCOut, YIn.
- T5: COut, ZIn, ALUCode=5'b00011.
- T6: ZLoOut and PCIn only if ConOut=1, otherwise no enables.
- Then T0.
REQ-021 jr: T3: Gra, ROut, PCIn; then T0.
REQ-022 jal:
- T3: PCOut, Grb, RIn (link into Rb).
- T4: Gra, ROut, PCIn.
- Then T0.
REQ-023 nop: T3 asserts nothing; then T0.
REQ-024 halt: T3 goes to HALT.
- HALT SHALL hold with all outputs 0 and run=0 until clear.
REQ-025 Latency in clocks, fetch included:
- jr and nop: 4.
- jal: 5.
- ALU ops and addi: 6.
- br: 7.
- ld and st: 8.
REQ-026 At most one bus-drive select SHALL be high in any state.
- Applies to HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut, ROut and BAOut.
REQ-027 memread and memwrite SHALL never be high in the same state.
REQ-028 HiIn, LoIn, OPortIn, HiOut, LoOut, ZHiOut, IPortOut and Grc outside ALU ops SHALL remain 0 for the implemented opcode set.

Reset
REQ-029 While clear=1:
- The FSM SHALL be in RST immediately, without waiting for a clock edge.
- All outputs SHALL be 0 and run=0.
REQ-030 On the first rising edge after clear falls, the FSM SHALL enter T0 and run=1.
REQ-031 If clear is asserted mid-instruction (e.g., ld in T6), the block SHALL abort.
- No further strobes SHALL be issued.
- The machine SHALL restart at fetch T0.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Reset: clear pulse, then release -> RST outputs all 0; next edge T0 with PCOut=MARIn=ZIn=1 and ALUCode=5'b11111.
- jr: IR=32'hA0000000 (opcode 10100) -> T3 Gra=ROut=PCIn=1; then T0; 4 clocks total.
- add: opcode 00011 -> T4 ALUCode=5'b00011 with Grc=ROut=ZIn=1; T5 ZLoOut=Gra=RIn=1; 6 clocks.
- br: opcode 10011 with ConOut=0 -> T6 PCIn=0; repeat with ConOut=1 -> T6 ZLoOut=PCIn=1.
- st: opcode 00010 -> T7 memwrite=1, memread=0; 8 clocks; one-hot bus-drive assertion checked every cycle.
- Halt and abort: opcode 11011 -> HALT, run=0 held 20 clocks. Separately, clear asserted during ld T6 -> memread drops at once; fetch restarts.

Source files
------------

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for a 32-bit single-bus datapath.
// Fetch T0..T2, opcode-dependent execute T3..T7, HALT until clear.
module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        ConOut,
    output logic        HiIn,
    output logic        LoIn,
    output logic        ZIn,
    output logic        PCIn,
    output logic        MDRIn,
    output logic        MARIn,
    output logic        YIn,
    output logic        OPortIn,
    output logic        IRIn,
    output logic        HiOut,
    output logic        LoOut,
    output logic        ZHiOut,
    output logic        ZLoOut,
    output logic        PCOut,
    output logic        MDROut,
    output logic        IPortOut,
    output logic        COut,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        RIn,
    output logic        ROut,
    output logic        BAOut,
    output logic        Conin,
    output logic        memread,
    output logic        memwrite,
    output logic [4:0]  ALUCode,
    output logic        run
);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_INC = 5'b11111;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t     r_state;
    logic [4:0] w_op;
    logic       w_alu;
    logic       w_mem;
    logic       w_unused;

    assign w_op     = IR[31:27];
    assign w_alu    = (w_op == OP_ADD) || (w_op == OP_SUB) ||
                      (w_op == OP_AND) || (w_op == OP_OR);
    assign w_mem    = (w_op == OP_LD) || (w_op == OP_ST);
    assign w_unused = ^IR[26:0];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= S_RST;
        end else begin
            case (r_state)
                S_RST: r_state <= S_T0;
                S_T0:  r_state <= S_T1;
                S_T1:  r_state <= S_T2;
                S_T2:  r_state <= S_T3;
                S_T3: begin
                    if (w_op == OP_HALT)
                        r_state <= S_HALT;
                    else if (w_alu || w_mem || (w_op == OP_ADDI) ||
                             (w_op == OP_BR) || (w_op == OP_JAL))
                        r_state <= S_T4;
                    else
                        r_state <= S_T0;
                end
                S_T4:  r_state <= (w_op == OP_JAL) ? S_T0 : S_T5;
                S_T5:  r_state <= (w_alu || (w_op == OP_ADDI)) ? S_T0 : S_T6;
                S_T6:  r_state <= (w_op == OP_BR) ? S_T0 : S_T7;
                S_T7:  r_state <= S_T0;
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_RST;
            endcase
        end
    end

    // Outputs decode from state and the live IR: IR is loaded on the T2->T3
    // edge, so a registered T3 decode would still see the previous opcode.
    always_comb begin
        HiIn = 1'b0;  LoIn = 1'b0;  ZIn = 1'b0;  PCIn = 1'b0;  MDRIn = 1'b0;
        MARIn = 1'b0; YIn = 1'b0;   OPortIn = 1'b0; IRIn = 1'b0;
        HiOut = 1'b0; LoOut = 1'b0; ZHiOut = 1'b0; ZLoOut = 1'b0;
        PCOut = 1'b0; MDROut = 1'b0; IPortOut = 1'b0; COut = 1'b0;
        Gra = 1'b0;   Grb = 1'b0;   Grc = 1'b0;  RIn = 1'b0;  ROut = 1'b0;
        BAOut = 1'b0; Conin = 1'b0; memread = 1'b0; memwrite = 1'b0;
        ALUCode = '0;
        run = (r_state != S_RST) && (r_state != S_HALT);

        case (r_state)
            S_T0: begin
                PCOut = 1'b1; MARIn = 1'b1; ZIn = 1'b1; ALUCode = ALU_INC;
            end
            S_T1: begin
                ZLoOut = 1'b1; PCIn = 1'b1; memread = 1'b1; MDRIn = 1'b1;
            end
            S_T2: begin
                MDROut = 1'b1; IRIn = 1'b1;
            end
            S_T3: begin
                if (w_alu || (w_op == OP_ADDI)) begin
                    Grb = 1'b1; ROut = 1'b1; YIn = 1'b1;
                end else if (w_mem) begin
                    Grb = 1'b1; BAOut = 1'b1; YIn = 1'b1;
                end else if (w_op == OP_BR) begin
                    Gra = 1'b1; ROut = 1'b1; Conin = 1'b1;
                end else if (w_op == OP_JR) begin
                    Gra = 1'b1; ROut = 1'b1; PCIn = 1'b1;
                end else if (w_op == OP_JAL) begin
                    PCOut = 1'b1; Grb = 1'b1; RIn = 1'b1;
                end
            end
            S_T4: begin
                if (w_alu) begin
                    Grc = 1'b1; ROut = 1'b1; ZIn = 1'b1; ALUCode = w_op;
                end else if (w_mem || (w_op == OP_ADDI)) begin
                    COut = 1'b1; ZIn = 1'b1; ALUCode = ALU_ADD;
                end else if (w_op == OP_BR) begin
                    PCOut = 1'b1; YIn = 1'b1;
                end else if (w_op == OP_JAL) begin
                    Gra = 1'b1; ROut = 1'b1; PCIn = 1'b1;
                end
            end
            S_T5: begin
                if (w_alu || (w_op == OP_ADDI)) begin
                    ZLoOut = 1'b1; Gra = 1'b1; RIn = 1'b1;
                end else if (w_mem) begin
                    ZLoOut = 1'b1; MARIn = 1'b1;
                end else if (w_op == OP_BR) begin
                    COut = 1'b1; ZIn = 1'b1; ALUCode = ALU_ADD;
                end
            end
            S_T6: begin
                if (w_op == OP_LD) begin
                    memread = 1'b1; MDRIn = 1'b1;
                end else if (w_op == OP_ST) begin
                    Gra = 1'b1; ROut = 1'b1; MDRIn = 1'b1;
                end else if ((w_op == OP_BR) && ConOut) begin
                    ZLoOut = 1'b1; PCIn = 1'b1;
                end
            end
            S_T7: begin
                if (w_op == OP_LD) begin
                    MDROut = 1'b1; Gra = 1'b1; RIn = 1'b1;
                end else if (w_op == OP_ST) begin
                    memwrite = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: every state's full output vector is
// compared against hand-built masks, plus per-cycle bus/memory exclusivity.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] IR;
    logic        ConOut;
    logic HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
    logic HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut;
    logic Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite, run;
    logic [4:0] ALUCode;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    control_unit dut (
        .clock(clock), .clear(clear), .IR(IR), .ConOut(ConOut),
        .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn),
        .MARIn(MARIn), .YIn(YIn), .OPortIn(OPortIn), .IRIn(IRIn),
        .HiOut(HiOut), .LoOut(LoOut), .ZHiOut(ZHiOut), .ZLoOut(ZLoOut),
        .PCOut(PCOut), .MDROut(MDROut), .IPortOut(IPortOut), .COut(COut),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .RIn(RIn), .ROut(ROut),
        .BAOut(BAOut), .Conin(Conin), .memread(memread), .memwrite(memwrite),
        .ALUCode(ALUCode), .run(run)
    );

    always #5 clock = ~clock;

    localparam logic [31:0] M_HIIN    = 32'h1 << 31;
    localparam logic [31:0] M_LOIN    = 32'h1 << 30;
    localparam logic [31:0] M_ZIN     = 32'h1 << 29;
    localparam logic [31:0] M_PCIN    = 32'h1 << 28;
    localparam logic [31:0] M_MDRIN   = 32'h1 << 27;
    localparam logic [31:0] M_MARIN   = 32'h1 << 26;
    localparam logic [31:0] M_YIN     = 32'h1 << 25;
    localparam logic [31:0] M_OPORTIN = 32'h1 << 24;
    localparam logic [31:0] M_IRIN    = 32'h1 << 23;
    localparam logic [31:0] M_HIOUT   = 32'h1 << 22;
    localparam logic [31:0] M_LOOUT   = 32'h1 << 21;
    localparam logic [31:0] M_ZHIOUT  = 32'h1 << 20;
    localparam logic [31:0] M_ZLOOUT  = 32'h1 << 19;
    localparam logic [31:0] M_PCOUT   = 32'h1 << 18;
    localparam logic [31:0] M_MDROUT  = 32'h1 << 17;
    localparam logic [31:0] M_IPORT   = 32'h1 << 16;
    localparam logic [31:0] M_COUT    = 32'h1 << 15;
    localparam logic [31:0] M_GRA     = 32'h1 << 14;
    localparam logic [31:0] M_GRB     = 32'h1 << 13;
    localparam logic [31:0] M_GRC     = 32'h1 << 12;
    localparam logic [31:0] M_RIN     = 32'h1 << 11;
    localparam logic [31:0] M_ROUT    = 32'h1 << 10;
    localparam logic [31:0] M_BAOUT   = 32'h1 << 9;
    localparam logic [31:0] M_CONIN   = 32'h1 << 8;
    localparam logic [31:0] M_MEMRD   = 32'h1 << 7;
    localparam logic [31:0] M_MEMWR   = 32'h1 << 6;
    localparam logic [31:0] M_RUN     = 32'h1 << 5;

    localparam logic [31:0] E_T0 = M_RUN | M_PCOUT | M_MARIN | M_ZIN | 32'h1F;
    localparam logic [31:0] E_T1 = M_RUN | M_ZLOOUT | M_PCIN | M_MEMRD | M_MDRIN;
    localparam logic [31:0] E_T2 = M_RUN | M_MDROUT | M_IRIN;

    logic [31:0] w_sig;
    assign w_sig = {HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
                    HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
                    Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite,
                    run, ALUCode};

    logic [9:0] w_bus;
    assign w_bus = {HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut,
                    COut, ROut, BAOut};

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Compare the current state's outputs, then advance one clock.
    task automatic expect_step(input string tag, input logic [31:0] exp);
        check(tag, w_sig, exp);
        step();
    endtask

    // Checks T0..T2 starting in T0; leaves the FSM in T3 with IR loaded.
    task automatic fetch(input string tag, input logic [4:0] op);
        IR = {op, 27'h0};
        expect_step({tag, "_T0"}, E_T0);
        expect_step({tag, "_T1"}, E_T1);
        expect_step({tag, "_T2"}, E_T2);
    endtask

    always @(negedge clock) begin
        check("bus_onehot", {31'h0, $onehot0(w_bus)}, 32'h1);
        check("mem_excl", {31'h0, memread & memwrite}, 32'h0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear  = 1'b1;
        IR     = 32'h0;
        ConOut = 1'b0;
        #12;
        check("reset", w_sig, 32'h0);
        clear = 1'b0;
        step();

        // jr: 4 clocks, T3 Gra/ROut/PCIn
        fetch("jr", 5'b10100);
        check("jr_ir", IR, 32'hA0000000);
        expect_step("jr_T3", M_RUN | M_GRA | M_ROUT | M_PCIN);

        fetch("add", 5'b00011);
        expect_step("add_T3", M_RUN | M_GRB | M_ROUT | M_YIN);
        expect_step("add_T4", M_RUN | M_GRC | M_ROUT | M_ZIN | 32'h03);
        expect_step("add_T5", M_RUN | M_ZLOOUT | M_GRA | M_RIN);

        fetch("sub", 5'b00100);
        expect_step("sub_T3", M_RUN | M_GRB | M_ROUT | M_YIN);
        expect_step("sub_T4", M_RUN | M_GRC | M_ROUT | M_ZIN | 32'h04);
        expect_step("sub_T5", M_RUN | M_ZLOOUT | M_GRA | M_RIN);

        fetch("addi", 5'b01100);
        expect_step("addi_T3", M_RUN | M_GRB | M_ROUT | M_YIN);
        expect_step("addi_T4", M_RUN | M_COUT | M_ZIN | 32'h03);
        expect_step("addi_T5", M_RUN | M_ZLOOUT | M_GRA | M_RIN);

        ConOut = 1'b0;
        fetch("br0", 5'b10011);
        expect_step("br0_T3", M_RUN | M_GRA | M_ROUT | M_CONIN);
        expect_step("br0_T4", M_RUN | M_PCOUT | M_YIN);
        expect_step("br0_T5", M_RUN | M_COUT | M_ZIN | 32'h03);
        expect_step("br0_T6", M_RUN);

        fetch("br1", 5'b10011);
        expect_step("br1_T3", M_RUN | M_GRA | M_ROUT | M_CONIN);
        expect_step("br1_T4", M_RUN | M_PCOUT | M_YIN);
        ConOut = 1'b1;
        expect_step("br1_T5", M_RUN | M_COUT | M_ZIN | 32'h03);
        expect_step("br1_T6", M_RUN | M_ZLOOUT | M_PCIN);
        ConOut = 1'b0;

        fetch("st", 5'b00010);
        expect_step("st_T3", M_RUN | M_GRB | M_BAOUT | M_YIN);
        expect_step("st_T4", M_RUN | M_COUT | M_ZIN | 32'h03);
        expect_step("st_T5", M_RUN | M_ZLOOUT | M_MARIN);
        expect_step("st_T6", M_RUN | M_GRA | M_ROUT | M_MDRIN);
        expect_step("st_T7", M_RUN | M_MEMWR);

        fetch("ld", 5'b00000);
        expect_step("ld_T3", M_RUN | M_GRB | M_BAOUT | M_YIN);
        expect_step("ld_T4", M_RUN | M_COUT | M_ZIN | 32'h03);
        expect_step("ld_T5", M_RUN | M_ZLOOUT | M_MARIN);
        expect_step("ld_T6", M_RUN | M_MEMRD | M_MDRIN);
        expect_step("ld_T7", M_RUN | M_MDROUT | M_GRA | M_RIN);

        fetch("jal", 5'b10101);
        expect_step("jal_T3", M_RUN | M_PCOUT | M_GRB | M_RIN);
        expect_step("jal_T4", M_RUN | M_GRA | M_ROUT | M_PCIN);

        fetch("nop", 5'b11010);
        expect_step("nop_T3", M_RUN);

        fetch("undef", 5'b11111);
        expect_step("undef_T3", M_RUN);

        fetch("halt", 5'b11011);
        expect_step("halt_T3", M_RUN);
        for (int i = 0; i < 20; i++)
            expect_step("halt_hold", 32'h0);
        #2 clear = 1'b1;
        #1 check("halt_clear", w_sig, 32'h0);
        step();
        clear = 1'b0;
        step();

        // Abort ld in T6: strobe must drop without waiting for an edge.
        fetch("ab", 5'b00000);
        expect_step("ab_T3", M_RUN | M_GRB | M_BAOUT | M_YIN);
        expect_step("ab_T4", M_RUN | M_COUT | M_ZIN | 32'h03);
        expect_step("ab_T5", M_RUN | M_ZLOOUT | M_MARIN);
        check("ab_T6", w_sig, M_RUN | M_MEMRD | M_MDRIN);
        #2 clear = 1'b1;
        #1 check("ab_async", w_sig, 32'h0);
        step();
        check("ab_held", w_sig, 32'h0);
        clear = 1'b0;
        step();
        fetch("restart", 5'b11010);
        expect_step("restart_T3", M_RUN);
        check("restart_T0", w_sig, E_T0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
